// File: rtl/memory_writeback.sv
// Memory-access and write-back stage of the multi-cycle RV32I core.
// Runs one data-memory transaction for loads/stores, then retires in a single WB cycle.
module memory_writeback #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        execute_i_valid,
  output logic        wb_o_ready,
  input  logic [31:0] execute_i_valE,
  input  logic [31:0] execute_i_pre_pc,
  input  logic [31:0] select_pc_i_pc,
  input  logic [31:0] decode_i_reg_valB,
  input  logic [4:0]  decode_i_rd,
  input  logic        decode_i_reg_we,
  input  logic        decode_i_mem_rd,
  input  logic        decode_i_mem_wr,
  input  logic [1:0]  decode_i_mem_size,
  input  logic        decode_i_mem_unsigned,
  input  logic [1:0]  decode_i_wb_sel,
  output logic        dmem_o_req_valid,
  input  logic        dmem_i_req_ready,
  output logic [31:0] dmem_o_addr,
  output logic        dmem_o_wen,
  output logic [31:0] dmem_o_wdata,
  output logic [3:0]  dmem_o_wmask,
  input  logic        dmem_i_resp_valid,
  input  logic [31:0] dmem_i_rdata,
  output logic        wb_o_rf_we,
  output logic [4:0]  wb_o_rf_waddr,
  output logic [31:0] wb_o_rf_wdata,
  output logic        wb_o_pc_we,
  output logic [31:0] wb_o_next_pc,
  output logic        wb_o_misalign
);

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_RESP, WB} state_t;

  state_t      state;
  logic [31:0] l_addr;
  logic [31:0] l_pre_pc;
  logic [31:0] l_pc;
  logic [4:0]  l_rd;
  logic        l_reg_we;
  logic        l_store;
  logic [1:0]  l_size;
  logic        l_uns;
  logic [1:0]  l_wb_sel;

  logic        misalign_c;

  // Size 11 is treated as word, so size[1] covers both word encodings.
  assign misalign_c = ((decode_i_mem_size == 2'b01) && execute_i_valE[0]) ||
                      (decode_i_mem_size[1] && (execute_i_valE[1:0] != 2'b00));

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_mask = 4'b0001 << off;
      2'b01:   store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] v);
    case (size)
      2'b00:   store_data = {4{v[7:0]}};
      2'b01:   store_data = {2{v[15:0]}};
      default: store_data = v;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   load_ext = {{24{~uns & b[7]}}, b};
      2'b01:   load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = rdata;
    endcase
  endfunction

  function automatic logic [31:0] wb_data(input logic [1:0] sel, input logic [31:0] vale,
                                          input logic [31:0] ld, input logic [31:0] pc);
    case (sel)
      2'b01:   wb_data = ld;
      2'b10:   wb_data = pc + 32'd4;
      default: wb_data = vale;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wb_o_ready       <= 1'b1;
      dmem_o_req_valid <= 1'b0;
      dmem_o_addr      <= '0;
      dmem_o_wen       <= 1'b0;
      dmem_o_wdata     <= '0;
      dmem_o_wmask     <= '0;
      wb_o_rf_we       <= 1'b0;
      wb_o_rf_waddr    <= '0;
      wb_o_rf_wdata    <= '0;
      wb_o_pc_we       <= 1'b0;
      wb_o_next_pc     <= RESET_PC;
      wb_o_misalign    <= 1'b0;
      l_addr           <= '0;
      l_pre_pc         <= '0;
      l_pc             <= '0;
      l_rd             <= '0;
      l_reg_we         <= 1'b0;
      l_store          <= 1'b0;
      l_size           <= '0;
      l_uns            <= 1'b0;
      l_wb_sel         <= '0;
    end else begin
      case (state)
        IDLE: if (execute_i_valid) begin
          l_addr     <= execute_i_valE;
          l_pre_pc   <= execute_i_pre_pc;
          l_pc       <= select_pc_i_pc;
          l_rd       <= decode_i_rd;
          l_reg_we   <= decode_i_reg_we;
          l_store    <= decode_i_mem_wr;
          l_size     <= decode_i_mem_size;
          l_uns      <= decode_i_mem_unsigned;
          l_wb_sel   <= decode_i_wb_sel;
          wb_o_ready <= 1'b0;
          if ((decode_i_mem_rd || decode_i_mem_wr) && misalign_c) begin
            state         <= WB;
            wb_o_misalign <= 1'b1;
          end else if (decode_i_mem_rd || decode_i_mem_wr) begin
            state            <= MEM_REQ;
            dmem_o_req_valid <= 1'b1;
            dmem_o_addr      <= {execute_i_valE[31:2], 2'b00};
            dmem_o_wen       <= decode_i_mem_wr;
            dmem_o_wdata     <= decode_i_mem_wr ?
                                store_data(decode_i_mem_size, decode_i_reg_valB) : 32'd0;
            dmem_o_wmask     <= decode_i_mem_wr ?
                                store_mask(decode_i_mem_size, execute_i_valE[1:0]) : 4'd0;
          end else begin
            state         <= WB;
            wb_o_rf_we    <= decode_i_reg_we && (decode_i_rd != 5'd0);
            wb_o_rf_waddr <= decode_i_rd;
            wb_o_rf_wdata <= wb_data(decode_i_wb_sel, execute_i_valE, 32'd0, select_pc_i_pc);
            wb_o_pc_we    <= 1'b1;
            wb_o_next_pc  <= execute_i_pre_pc;
          end
        end
        MEM_REQ: if (dmem_i_req_ready) begin
          dmem_o_req_valid <= 1'b0;
          dmem_o_addr      <= '0;
          dmem_o_wen       <= 1'b0;
          dmem_o_wdata     <= '0;
          dmem_o_wmask     <= '0;
          if (l_store) begin
            state         <= WB;
            wb_o_rf_we    <= l_reg_we && (l_rd != 5'd0);
            wb_o_rf_waddr <= l_rd;
            wb_o_rf_wdata <= wb_data(l_wb_sel, l_addr, 32'd0, l_pc);
            wb_o_pc_we    <= 1'b1;
            wb_o_next_pc  <= l_pre_pc;
          end else begin
            state <= MEM_RESP;
          end
        end
        MEM_RESP: if (dmem_i_resp_valid) begin
          state         <= WB;
          wb_o_rf_we    <= l_reg_we && (l_rd != 5'd0);
          wb_o_rf_waddr <= l_rd;
          wb_o_rf_wdata <= wb_data(l_wb_sel, l_addr,
                                   load_ext(l_size, l_uns, l_addr[1:0], dmem_i_rdata), l_pc);
          wb_o_pc_we    <= 1'b1;
          wb_o_next_pc  <= l_pre_pc;
        end
        WB: begin
          state         <= IDLE;
          wb_o_ready    <= 1'b1;
          wb_o_rf_we    <= 1'b0;
          wb_o_pc_we    <= 1'b0;
          wb_o_misalign <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_writeback.sv
// Directed bench for memory_writeback: table of register-only ops plus
// hand-written load/store, back-pressure, misalign and reset sequences.
module tb_memory_writeback;

  logic        clk;
  logic        rst;
  logic        execute_i_valid;
  logic        wb_o_ready;
  logic [31:0] execute_i_valE;
  logic [31:0] execute_i_pre_pc;
  logic [31:0] select_pc_i_pc;
  logic [31:0] decode_i_reg_valB;
  logic [4:0]  decode_i_rd;
  logic        decode_i_reg_we;
  logic        decode_i_mem_rd;
  logic        decode_i_mem_wr;
  logic [1:0]  decode_i_mem_size;
  logic        decode_i_mem_unsigned;
  logic [1:0]  decode_i_wb_sel;
  logic        dmem_o_req_valid;
  logic        dmem_i_req_ready;
  logic [31:0] dmem_o_addr;
  logic        dmem_o_wen;
  logic [31:0] dmem_o_wdata;
  logic [3:0]  dmem_o_wmask;
  logic        dmem_i_resp_valid;
  logic [31:0] dmem_i_rdata;
  logic        wb_o_rf_we;
  logic [4:0]  wb_o_rf_waddr;
  logic [31:0] wb_o_rf_wdata;
  logic        wb_o_pc_we;
  logic [31:0] wb_o_next_pc;
  logic        wb_o_misalign;

  memory_writeback #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .execute_i_valid(execute_i_valid), .wb_o_ready(wb_o_ready),
    .execute_i_valE(execute_i_valE), .execute_i_pre_pc(execute_i_pre_pc),
    .select_pc_i_pc(select_pc_i_pc), .decode_i_reg_valB(decode_i_reg_valB),
    .decode_i_rd(decode_i_rd), .decode_i_reg_we(decode_i_reg_we),
    .decode_i_mem_rd(decode_i_mem_rd), .decode_i_mem_wr(decode_i_mem_wr),
    .decode_i_mem_size(decode_i_mem_size), .decode_i_mem_unsigned(decode_i_mem_unsigned),
    .decode_i_wb_sel(decode_i_wb_sel),
    .dmem_o_req_valid(dmem_o_req_valid), .dmem_i_req_ready(dmem_i_req_ready),
    .dmem_o_addr(dmem_o_addr), .dmem_o_wen(dmem_o_wen),
    .dmem_o_wdata(dmem_o_wdata), .dmem_o_wmask(dmem_o_wmask),
    .dmem_i_resp_valid(dmem_i_resp_valid), .dmem_i_rdata(dmem_i_rdata),
    .wb_o_rf_we(wb_o_rf_we), .wb_o_rf_waddr(wb_o_rf_waddr), .wb_o_rf_wdata(wb_o_rf_wdata),
    .wb_o_pc_we(wb_o_pc_we), .wb_o_next_pc(wb_o_next_pc), .wb_o_misalign(wb_o_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vale;
    logic [31:0] pre_pc;
    logic [31:0] pc;
    logic [31:0] valb;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  wb_sel;
  } op_t;

  typedef struct {
    op_t         op;
    logic        exp_rf_we;
    logic [31:0] exp_wdata;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t mk(input logic [31:0] vale, input logic [31:0] pre_pc,
                             input logic [31:0] pc, input logic [31:0] valb,
                             input logic [4:0] rd, input logic reg_we, input logic mem_rd,
                             input logic mem_wr, input logic [1:0] size, input logic uns,
                             input logic [1:0] wb_sel);
    op_t o;
    o.vale = vale; o.pre_pc = pre_pc; o.pc = pc; o.valb = valb; o.rd = rd;
    o.reg_we = reg_we; o.mem_rd = mem_rd; o.mem_wr = mem_wr; o.size = size;
    o.uns = uns; o.wb_sel = wb_sel;
    return o;
  endfunction

  task automatic drive(input op_t o);
    execute_i_valid       = 1'b1;
    execute_i_valE        = o.vale;
    execute_i_pre_pc      = o.pre_pc;
    select_pc_i_pc        = o.pc;
    decode_i_reg_valB     = o.valb;
    decode_i_rd           = o.rd;
    decode_i_reg_we       = o.reg_we;
    decode_i_mem_rd       = o.mem_rd;
    decode_i_mem_wr       = o.mem_wr;
    decode_i_mem_size     = o.size;
    decode_i_mem_unsigned = o.uns;
    decode_i_wb_sel       = o.wb_sel;
  endtask

  // Load with zero-wait request; resp arrives resp_delay cycles after MEM_RESP entry.
  // A bogus response is offered during the handshake cycle and must be ignored.
  task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] rdata, input int resp_delay,
                          input logic [31:0] exp_wdata);
    logic [31:0] pre;
    pre = addr + 32'h40;
    drive(mk(addr, pre, 32'h8000_0050, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, size, uns, 2'b01));
    dmem_i_req_ready = 1'b1;
    step();
    execute_i_valid = 1'b0;
    chk({name, " req_valid"}, 32'(dmem_o_req_valid), 32'd1);
    chk({name, " addr"}, dmem_o_addr, {addr[31:2], 2'b00});
    chk({name, " wen"}, 32'(dmem_o_wen), 32'd0);
    dmem_i_resp_valid = 1'b1;
    dmem_i_rdata = 32'h1111_1111;
    step();
    dmem_i_resp_valid = 1'b0;
    chk({name, " req_dropped"}, 32'(dmem_o_req_valid), 32'd0);
    for (int i = 0; i < resp_delay; i++) begin
      step();
      chk({name, " no_early_wb"}, 32'(wb_o_rf_we), 32'd0);
    end
    dmem_i_resp_valid = 1'b1;
    dmem_i_rdata = rdata;
    step();
    dmem_i_resp_valid = 1'b0;
    chk({name, " rf_we"}, 32'(wb_o_rf_we), 32'd1);
    chk({name, " wdata"}, wb_o_rf_wdata, exp_wdata);
    chk({name, " next_pc"}, wb_o_next_pc, pre);
    step();
    chk({name, " ready"}, 32'(wb_o_ready), 32'd1);
    last_pc = pre;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{mk(32'h30, 32'h8000_0004, 32'h8000_0000, 0, 5'd5, 1, 0, 0, 2'b10, 0, 2'b00),
                1'b1, 32'h30};
    vecs[1] = '{mk(32'h0, 32'h8000_0100, 32'h8000_0010, 0, 5'd1, 1, 0, 0, 2'b10, 0, 2'b10),
                1'b1, 32'h8000_0014};
    vecs[2] = '{mk(32'h0, 32'h8000_0200, 32'h8000_0010, 0, 5'd0, 1, 0, 0, 2'b10, 0, 2'b10),
                1'b0, 32'h0};
    vecs[3] = '{mk(32'hDEAD_BEEF, 32'h8000_0208, 32'h8000_0204, 0, 5'd31, 1, 0, 0, 2'b10, 0, 2'b11),
                1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{mk(32'h5, 32'h0000_0000, 32'hFFFF_FFFC, 0, 5'd2, 1, 0, 0, 2'b10, 0, 2'b10),
                1'b1, 32'h0000_0000};
    vecs[5] = '{mk(32'h77, 32'h8000_0300, 32'h8000_02FC, 0, 5'd9, 0, 0, 0, 2'b10, 0, 2'b00),
                1'b0, 32'h0};

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    execute_i_valid   = 1'b0;
    dmem_i_req_ready  = 1'b0;
    dmem_i_resp_valid = 1'b0;
    dmem_i_rdata      = 32'd0;
    step();
    step();
    rst = 1'b0;

    chk("rst ready", 32'(wb_o_ready), 32'd1);
    chk("rst req_valid", 32'(dmem_o_req_valid), 32'd0);
    chk("rst addr", dmem_o_addr, 32'd0);
    chk("rst wen", 32'(dmem_o_wen), 32'd0);
    chk("rst wdata", dmem_o_wdata, 32'd0);
    chk("rst wmask", 32'(dmem_o_wmask), 32'd0);
    chk("rst rf_we", 32'(wb_o_rf_we), 32'd0);
    chk("rst waddr", 32'(wb_o_rf_waddr), 32'd0);
    chk("rst rf_wdata", wb_o_rf_wdata, 32'd0);
    chk("rst pc_we", 32'(wb_o_pc_we), 32'd0);
    chk("rst misalign", 32'(wb_o_misalign), 32'd0);
    chk("rst next_pc", wb_o_next_pc, 32'h8000_0000);

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].op);
      step();
      execute_i_valid = 1'b0;
      chk($sformatf("vec%0d rf_we", i), 32'(wb_o_rf_we), 32'(vecs[i].exp_rf_we));
      if (vecs[i].exp_rf_we) begin
        chk($sformatf("vec%0d waddr", i), 32'(wb_o_rf_waddr), 32'(vecs[i].op.rd));
        chk($sformatf("vec%0d wdata", i), wb_o_rf_wdata, vecs[i].exp_wdata);
      end
      chk($sformatf("vec%0d pc_we", i), 32'(wb_o_pc_we), 32'd1);
      chk($sformatf("vec%0d next_pc", i), wb_o_next_pc, vecs[i].op.pre_pc);
      chk($sformatf("vec%0d ready_low", i), 32'(wb_o_ready), 32'd0);
      step();
      chk($sformatf("vec%0d ready", i), 32'(wb_o_ready), 32'd1);
      chk($sformatf("vec%0d pc_we_drop", i), 32'(wb_o_pc_we), 32'd0);
      last_pc = vecs[i].op.pre_pc;
    end

    run_load("LB",  32'h8000_0103, 2'b00, 1'b0, 32'h80AA_BBCC, 1, 32'hFFFF_FF80);
    run_load("LBU", 32'h8000_0103, 2'b00, 1'b1, 32'h80AA_BBCC, 1, 32'h0000_0080);
    run_load("LH",  32'h8000_0102, 2'b01, 1'b0, 32'h80AA_BBCC, 0, 32'hFFFF_80AA);
    run_load("LHU", 32'h8000_0102, 2'b01, 1'b1, 32'h80AA_BBCC, 2, 32'h0000_80AA);
    run_load("LW",  32'h8000_0104, 2'b10, 1'b0, 32'h80AA_BBCC, 0, 32'h80AA_BBCC);

    // SH under back-pressure: request held for four cycles.
    drive(mk(32'h8000_0102, 32'h8000_0300, 32'h8000_02FC, 32'h1234_ABCD, 5'd0, 0, 0, 1,
             2'b01, 0, 2'b00));
    dmem_i_req_ready = 1'b0;
    step();
    execute_i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("SH c%0d req_valid", i), 32'(dmem_o_req_valid), 32'd1);
      chk($sformatf("SH c%0d wmask", i), 32'(dmem_o_wmask), 32'hC);
      chk($sformatf("SH c%0d wdata", i), dmem_o_wdata, 32'hABCD_ABCD);
      chk($sformatf("SH c%0d wen", i), 32'(dmem_o_wen), 32'd1);
      chk($sformatf("SH c%0d addr", i), dmem_o_addr, 32'h8000_0100);
      chk($sformatf("SH c%0d pc_we", i), 32'(wb_o_pc_we), 32'd0);
      if (i == 3) dmem_i_req_ready = 1'b1;
      step();
    end
    chk("SH wb rf_we", 32'(wb_o_rf_we), 32'd0);
    chk("SH wb pc_we", 32'(wb_o_pc_we), 32'd1);
    chk("SH wb next_pc", wb_o_next_pc, 32'h8000_0300);
    chk("SH wb req_valid", 32'(dmem_o_req_valid), 32'd0);
    step();
    chk("SH ready", 32'(wb_o_ready), 32'd1);

    // SB zero-wait at byte offset 1.
    drive(mk(32'h8000_0201, 32'h8000_0304, 32'h8000_0300, 32'hFFFF_FF55, 5'd0, 0, 0, 1,
             2'b00, 0, 2'b00));
    step();
    execute_i_valid = 1'b0;
    chk("SB wmask", 32'(dmem_o_wmask), 32'h2);
    chk("SB wdata", dmem_o_wdata, 32'h5555_5555);
    chk("SB addr", dmem_o_addr, 32'h8000_0200);
    step();
    chk("SB pc_we", 32'(wb_o_pc_we), 32'd1);
    chk("SB next_pc", wb_o_next_pc, 32'h8000_0304);
    step();
    last_pc = 32'h8000_0304;

    // Misaligned LW: no request, misalign pulse, PC held.
    drive(mk(32'h8000_0002, 32'h8000_0400, 32'h8000_03FC, 0, 5'd4, 1, 1, 0, 2'b10, 0, 2'b01));
    step();
    execute_i_valid = 1'b0;
    chk("MIS misalign", 32'(wb_o_misalign), 32'd1);
    chk("MIS rf_we", 32'(wb_o_rf_we), 32'd0);
    chk("MIS pc_we", 32'(wb_o_pc_we), 32'd0);
    chk("MIS req_valid", 32'(dmem_o_req_valid), 32'd0);
    chk("MIS next_pc", wb_o_next_pc, last_pc);
    step();
    chk("MIS misalign_drop", 32'(wb_o_misalign), 32'd0);
    chk("MIS req_valid2", 32'(dmem_o_req_valid), 32'd0);
    chk("MIS ready", 32'(wb_o_ready), 32'd1);

    // Reset while in MEM_RESP, then a late response.
    drive(mk(32'h8000_0010, 32'h8000_0500, 32'h8000_04FC, 0, 5'd6, 1, 1, 0, 2'b10, 0, 2'b01));
    step();
    execute_i_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("RST ready", 32'(wb_o_ready), 32'd1);
    chk("RST next_pc", wb_o_next_pc, 32'h8000_0000);
    chk("RST req_valid", 32'(dmem_o_req_valid), 32'd0);
    chk("RST rf_we", 32'(wb_o_rf_we), 32'd0);
    dmem_i_resp_valid = 1'b1;
    dmem_i_rdata = 32'hCAFE_F00D;
    step();
    dmem_i_resp_valid = 1'b0;
    chk("RST late rf_we", 32'(wb_o_rf_we), 32'd0);
    chk("RST late pc_we", 32'(wb_o_pc_we), 32'd0);
    chk("RST late ready", 32'(wb_o_ready), 32'd1);
    drive(vecs[0].op);
    step();
    execute_i_valid = 1'b0;
    chk("POST add rf_we", 32'(wb_o_rf_we), 32'd1);
    chk("POST add wdata", wb_o_rf_wdata, 32'h30);
    chk("POST add next_pc", wb_o_next_pc, 32'h8000_0004);
    step();
    chk("POST add ready", 32'(wb_o_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
